// File: rtl/preg_free_list_pkg.sv
// FreeListTypes: shared widths and path types for the physical register free list.
//   Default geometry: 64 physical, 32 logical scalar registers, so 32 free-list entries
//   holding register numbers 32..63, with 2 rename lanes and 2 commit lanes.
package FreeListTypes;
  localparam int LSCALAR_NUM = 32;
  localparam int PSCALAR_NUM = 64;
  localparam int RENAME_WIDTH = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int PREG_NUM_BIT_WIDTH = $clog2(PSCALAR_NUM);
  localparam int FREE_LIST_ENTRY_NUM = PSCALAR_NUM - LSCALAR_NUM;
  typedef struct packed {
    logic [PREG_NUM_BIT_WIDTH-1:0] regNum;
  } PRegNumPath;
  typedef logic [$clog2(FREE_LIST_ENTRY_NUM)-1:0] FreeListIndexPath;
  typedef logic [$clog2(FREE_LIST_ENTRY_NUM):0] FreeListCountPath;
  typedef logic [$bits(PRegNumPath)-1:0] FreeListEntryPath;
endpackage

// File: rtl/preg_free_list_lane_compactor.sv
// free_list_lane_compactor: prefix count of a sparse request vector.
//   i_req    : per-lane request bits
//   o_offset : per lane, number of set request bits in lower lanes
//   o_total  : number of set request bits
module free_list_lane_compactor #(
  parameter int N = 2,
  localparam int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]         i_req,
  output logic [N-1:0][CW-1:0] o_offset,
  output logic [CW-1:0]        o_total
);
  logic [CW-1:0] w_acc;
  always_comb begin
    w_acc = '0;
    o_offset = '0;
    for (int k = 0; k < N; k++) begin
      o_offset[k] = w_acc;
      w_acc = w_acc + CW'(i_req[k]);
    end
  end
  assign o_total = w_acc;
endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: multi-port circular free list of physical register numbers.
//   clk          : clock
//   rstL         : asynchronous active-low reset (list full, entry i = RESET_BASE+i)
//   popReq       : per-lane pop request, lanes may be sparse
//   popData      : popped register number per lane, combinational from current state
//   popError     : pop dropped because more lanes requested than free entries
//   pushReq      : per-lane push request
//   pushData     : register number released on each lane
//   count        : number of free entries
//   canPop       : count >= POP_WIDTH
//   recover      : (RSD_FREE_LIST_RECOVERY_EN) rewind head to the committed head
//   commitPopNum : (RSD_FREE_LIST_RECOVERY_EN) entries committed this cycle
// Optional feature macro: RSD_FREE_LIST_RECOVERY_EN.
module preg_free_list
  import FreeListTypes::*;
#(
  parameter int ENTRY_NUM   = FREE_LIST_ENTRY_NUM,
  parameter int POP_WIDTH   = RENAME_WIDTH,
  parameter int PUSH_WIDTH  = COMMIT_WIDTH,
  parameter int ENTRY_WIDTH = PREG_NUM_BIT_WIDTH,
  parameter int RESET_BASE  = LSCALAR_NUM,
  localparam int IW  = $clog2(ENTRY_NUM),
  localparam int CW  = IW + 1,
  localparam int PCW = $clog2(POP_WIDTH) + 1,
  localparam int QCW = $clog2(PUSH_WIDTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rstL,
  input  logic [POP_WIDTH-1:0]                  popReq,
  output logic [POP_WIDTH-1:0][ENTRY_WIDTH-1:0] popData,
  output logic                                  popError,
  input  logic [PUSH_WIDTH-1:0]                 pushReq,
  input  logic [PUSH_WIDTH-1:0][ENTRY_WIDTH-1:0] pushData,
  output logic [CW-1:0]                         count,
`ifdef RSD_FREE_LIST_RECOVERY_EN
  input  logic                                  recover,
  input  logic [PCW-1:0]                        commitPopNum,
`endif
  output logic                                  canPop
);
  logic [ENTRY_WIDTH-1:0] r_mem [ENTRY_NUM];
  logic [CW-1:0] r_head, r_tail, w_head_next, w_commit_next;
  logic [POP_WIDTH-1:0][PCW-1:0] w_pop_off;
  logic [PUSH_WIDTH-1:0][QCW-1:0] w_push_off;
  logic [PCW-1:0] w_pop_total;
  logic [QCW-1:0] w_push_total;
  logic [POP_WIDTH-1:0][IW-1:0] w_ridx;
  logic [PUSH_WIDTH-1:0][IW-1:0] w_widx;
  logic w_recover;

  free_list_lane_compactor #(.N(POP_WIDTH)) u_pop_cmp (
    .i_req(popReq), .o_offset(w_pop_off), .o_total(w_pop_total)
  );
  free_list_lane_compactor #(.N(PUSH_WIDTH)) u_push_cmp (
    .i_req(pushReq), .o_offset(w_push_off), .o_total(w_push_total)
  );

`ifdef RSD_FREE_LIST_RECOVERY_EN
  logic [CW-1:0] r_commit;
  assign w_recover = recover;
  // Commit advance lands first, so a recover in the same cycle rewinds past it.
  assign w_commit_next = r_commit + CW'(commitPopNum);
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) r_commit <= '0;
    else r_commit <= w_commit_next;
  end
  a_commit_behind_head: assert property (@(posedge clk) disable iff (!rstL)
    (r_head - r_commit) <= CW'(ENTRY_NUM));
`else
  assign w_recover = 1'b0;
  assign w_commit_next = '0;
`endif

  // Pointers carry a wrap bit, so the modular difference is the occupancy.
  assign count = r_tail - r_head;
  assign canPop = count >= CW'(POP_WIDTH);
  assign popError = !w_recover && (CW'(w_pop_total) > count);
  assign w_head_next = w_recover ? w_commit_next :
                       popError  ? r_head : r_head + CW'(w_pop_total);

  always_comb begin
    for (int k = 0; k < POP_WIDTH; k++) begin
      w_ridx[k] = r_head[IW-1:0] + IW'(w_pop_off[k]);
      popData[k] = r_mem[w_ridx[k]];
    end
    for (int k = 0; k < PUSH_WIDTH; k++) w_widx[k] = r_tail[IW-1:0] + IW'(w_push_off[k]);
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      for (int i = 0; i < ENTRY_NUM; i++) r_mem[i] <= ENTRY_WIDTH'(RESET_BASE + i);
      r_head <= '0;
      r_tail <= CW'(ENTRY_NUM);
    end else begin
      for (int k = 0; k < PUSH_WIDTH; k++) if (pushReq[k]) r_mem[w_widx[k]] <= pushData[k];
      r_head <= w_head_next;
      r_tail <= r_tail + CW'(w_push_total);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstL)
    ({1'b0, count} + (CW+1)'(w_push_total)) <= (CW+1)'(ENTRY_NUM));
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: scoreboard bench for preg_free_list against a queue model.
module tb_preg_free_list;
  logic clk = 1'b0;
  logic rstL = 1'b1;
  logic [1:0] popReq = '0;
  logic [1:0][5:0] popData;
  logic popError;
  logic [1:0] pushReq = '0;
  logic [1:0][5:0] pushData = '0;
  logic [5:0] count;
  logic canPop;
`ifdef RSD_FREE_LIST_RECOVERY_EN
  logic recover = 1'b0;
  logic [1:0] commitPopNum = '0;
`endif
  int n_checks = 0;
  int n_fail = 0;
  int fl[$];
  int infl[$];
  int sb[$];

  preg_free_list dut (
    .clk(clk), .rstL(rstL), .popReq(popReq), .popData(popData), .popError(popError),
    .pushReq(pushReq), .pushData(pushData), .count(count),
`ifdef RSD_FREE_LIST_RECOVERY_EN
    .recover(recover), .commitPopNum(commitPopNum),
`endif
    .canPop(canPop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] auto_cpn();
    return infl.size() >= 2 ? 2'd2 : 2'(infl.size());
  endfunction

  task automatic step(input logic [1:0] pr, input logic [1:0] qr, input logic [5:0] d0,
                      input logic [5:0] d1, input logic rec, input logic [1:0] cpn);
    int cnt;
    logic err;
    @(negedge clk);
    popReq = pr;
    pushReq = qr;
    pushData[0] = d0;
    pushData[1] = d1;
`ifdef RSD_FREE_LIST_RECOVERY_EN
    recover = rec;
    commitPopNum = cpn;
`endif
    cnt = fl.size();
    err = !rec && (int'(pr[0]) + int'(pr[1]) > cnt);
    if (!rec && !err)
      for (int k = 0; k < 2; k++)
        if (pr[k]) begin
          sb.push_back(fl[0]);
          infl.push_back(fl.pop_front());
        end
    #1;
    check("count", 32'(count), 32'(cnt));
    check("canPop", 32'(canPop), 32'(cnt >= 2));
    check("popError", 32'(popError), 32'(err));
    if (!rec && !err)
      for (int k = 0; k < 2; k++)
        if (pr[k]) check($sformatf("popData%0d", k), 32'(popData[k]), 32'(sb.pop_front()));
    @(posedge clk);
    repeat (int'(cpn)) void'(infl.pop_front());
    if (rec) begin
      fl = {infl, fl};
      infl.delete();
    end
    if (qr[0]) fl.push_back(int'(d0));
    if (qr[1]) fl.push_back(int'(d1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    popReq = '0;
    pushReq = '0;
`ifdef RSD_FREE_LIST_RECOVERY_EN
    recover = 1'b0;
    commitPopNum = '0;
`endif
    #2 rstL = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd32);
    check("rst_canPop", 32'(canPop), 32'd1);
    check("rst_popError", 32'(popError), 32'd0);
    @(negedge clk);
    rstL = 1'b1;
    fl.delete();
    infl.delete();
    sb.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endtask

  initial begin
    logic [1:0] pr, qr;
    do_reset();
    for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b00, 2'b01, 6'd5, 6'd0, 1'b0, auto_cpn());
    step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());

    do_reset();
    step(2'b10, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());

    do_reset();
    for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    step(2'b11, 2'b01, 6'd40, 6'd0, 1'b0, auto_cpn());
    step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());

    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, auto_cpn());
    do_reset();
    for (int i = 0; i < 200; i++) begin
      pr = 2'($urandom_range(0, 3));
      qr = 2'($urandom_range(0, 3));
      if (fl.size() + int'(qr[0]) + int'(qr[1]) > 32) qr = 2'b00;
      step(pr, qr, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0, auto_cpn());
    end

`ifdef RSD_FREE_LIST_RECOVERY_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0);
    step(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'd2);
    step(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 2'd0);
    step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0);
    do_reset();
    for (int i = 0; i < 2; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0);
    step(2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 2'd2);
    step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0);
`endif

    @(negedge clk);
    popReq = '0;
    pushReq = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
